// File: rtl/battleship_pkg.sv
// battleship_pkg
// Shared definitions for the 28-cell battleship board. The attacker-side
// launcher and the defender-side hit logic both use them.
//   CELLS            : number of board cells (4 digits x 7 segments); cell i = bit i
//   cell_idx_t       : 5-bit cell index, legal range 0..CELLS-1
//   launcher_state_t : attacker launcher FSM states
//   cell_onehot()    : cell index -> one-hot board mask
package battleship_pkg;

    localparam int CELLS = 28;

    typedef logic [4:0] cell_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        AIM,
        FIRE,
        WAIT_RES,
        DONE
    } launcher_state_t;

    function automatic logic [CELLS-1:0] cell_onehot(input cell_idx_t idx);
        logic [CELLS-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/battleship_blink_timer.sv
// battleship_blink_timer
// Free-running half-period timer for the blinking cursor overlay.
// The counter runs 0..BLINK_DIV-1. The phase toggles each time the counter wraps.
//   clk     in   system clock
//   reset   in   synchronous active-high reset: counter 0, phase on
//   restart in   force counter 0, phase on (cursor moved / AIM entered)
//   phase   out  current blink phase (1 = cursor visible)
//   wrap    out  counter is at its last value; phase flips on the next edge
module battleship_blink_timer #(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic phase,
    output logic wrap
);

    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             phase_q, phase_d;

    assign wrap  = (count_q == LAST);
    assign phase = phase_q;

    always_comb begin
        count_d = count_q + CNT_W'(1);
        phase_d = phase_q;
        if (restart) begin
            count_d = '0;
            phase_d = 1'b1;
        end else if (wrap) begin
            count_d = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            phase_q <= 1'b1;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/battleship_torpedo_launcher.sv
// battleship_torpedo_launcher
// Attacker-side initiator for the torpedo exchange. Button pulses move a
// cursor across the board. A fire pulse offers a one-hot torpedo to the
// defender over valid/ready, and the launcher then waits for the hit/miss
// result. It keeps the fired/hit history and the shot budget. All outputs
// are registered.
//   clk, reset            system clock, synchronous active-high reset
//   enable                high while it is this attacker's turn
//   btn_next/btn_prev     single-cycle pulses, cursor +1 / -1 with wrap-around
//   btn_fire              single-cycle pulse, fire at the cursor
//   torp_valid/torp_mask  torpedo offer; mask is one-hot, zero when not valid
//   torp_ready            defender accepts the torpedo
//   res_valid/res_hit     result strobe from the defender and its hit flag
//   cursor_mask           blinking one-hot cursor overlay (AIM only)
//   fired_mask/hit_mask   shot history; hit_mask is a subset of fired_mask
//   shots_left            remaining torpedoes
//   reject                one-cycle pulse: fire on an already-fired cell
//   done                  shot budget exhausted (terminal until reset)
module battleship_torpedo_launcher
    import battleship_pkg::*;
#(
    parameter int MAX_SHOTS = 12,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             btn_fire,
    output logic             torp_valid,
    output logic [CELLS-1:0] torp_mask,
    input  logic             torp_ready,
    input  logic             res_valid,
    input  logic             res_hit,
    output logic [CELLS-1:0] cursor_mask,
    output logic [CELLS-1:0] fired_mask,
    output logic [CELLS-1:0] hit_mask,
    output logic [3:0]       shots_left,
    output logic             reject,
    output logic             done
);

    localparam cell_idx_t LAST_CELL = cell_idx_t'(CELLS - 1);

    launcher_state_t  state_q, state_d;
    cell_idx_t        cursor_q, cursor_d;
    cell_idx_t        target_q, target_d;
    logic [CELLS-1:0] fired_q, fired_d;
    logic [CELLS-1:0] hit_q, hit_d;
    logic [3:0]       shots_q, shots_d;
    logic             torp_valid_q, torp_valid_d;
    logic [CELLS-1:0] torp_mask_q, torp_mask_d;
    logic [CELLS-1:0] cursor_mask_q, cursor_mask_d;
    logic             reject_q, reject_d;
    logic             done_q, done_d;

    logic move;
    logic restart;
    logic blink_phase;
    logic blink_wrap;
    logic show_cursor;

    battleship_blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .phase   (blink_phase),
        .wrap    (blink_wrap)
    );

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        target_d = target_q;
        fired_d  = fired_q;
        hit_d    = hit_q;
        shots_d  = shots_q;
        reject_d = 1'b0;
        move     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) state_d = AIM;
            end
            AIM: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (btn_fire) begin
                    // Fire takes priority over moves; the cursor stays where it is.
                    if (fired_q[cursor_q]) begin
                        reject_d = 1'b1;
                    end else begin
                        target_d = cursor_q;
                        state_d  = FIRE;
                    end
                end else if (btn_next != btn_prev) begin
                    move = 1'b1;
                    if (btn_next) cursor_d = (cursor_q == LAST_CELL) ? '0 : cursor_q + 5'd1;
                    else          cursor_d = (cursor_q == '0) ? LAST_CELL : cursor_q - 5'd1;
                end
            end
            FIRE: begin
                if (torp_valid_q && torp_ready) state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (res_valid) begin
                    fired_d[target_q] = 1'b1;
                    hit_d[target_q]   = res_hit;
                    shots_d           = shots_q - 4'd1;
                    state_d           = (shots_q == 4'd1) ? DONE : AIM;
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed from next-state values so each one appears one
        // cycle after the event that causes it.
        restart       = move || ((state_d == AIM) && (state_q != AIM));
        show_cursor   = restart || (blink_phase ^ blink_wrap);
        cursor_mask_d = ((state_d == AIM) && show_cursor) ? cell_onehot(cursor_d) : '0;
        torp_valid_d  = (state_d == FIRE);
        torp_mask_d   = (state_d == FIRE) ? cell_onehot(target_d) : '0;
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cursor_q      <= '0;
            target_q      <= '0;
            fired_q       <= '0;
            hit_q         <= '0;
            shots_q       <= 4'(MAX_SHOTS);
            torp_valid_q  <= 1'b0;
            torp_mask_q   <= '0;
            cursor_mask_q <= '0;
            reject_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            target_q      <= target_d;
            fired_q       <= fired_d;
            hit_q         <= hit_d;
            shots_q       <= shots_d;
            torp_valid_q  <= torp_valid_d;
            torp_mask_q   <= torp_mask_d;
            cursor_mask_q <= cursor_mask_d;
            reject_q      <= reject_d;
            done_q        <= done_d;
        end
    end

    assign torp_valid  = torp_valid_q;
    assign torp_mask   = torp_mask_q;
    assign cursor_mask = cursor_mask_q;
    assign fired_mask  = fired_q;
    assign hit_mask    = hit_q;
    assign shots_left  = shots_q;
    assign reject      = reject_q;
    assign done        = done_q;

endmodule

// File: tb/tb_battleship_torpedo_launcher.sv
module tb_battleship_torpedo_launcher;

    localparam int NC    = 28;
    localparam int SHOTS = 3;
    localparam int BDIV  = 4;

    logic          clk = 1'b0;
    logic          reset, enable, btn_next, btn_prev, btn_fire;
    logic          torp_valid, torp_ready, res_valid, res_hit;
    logic [NC-1:0] torp_mask, cursor_mask, fired_mask, hit_mask;
    logic [3:0]    shots_left;
    logic          reject, done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int            m_cursor;
    int            m_target;
    int            m_shots;
    logic [NC-1:0] m_fired, m_hit;
    logic [NC-1:0] exp_torp_q [$];

    battleship_torpedo_launcher #(
        .MAX_SHOTS (SHOTS),
        .BLINK_DIV (BDIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .btn_next    (btn_next),
        .btn_prev    (btn_prev),
        .btn_fire    (btn_fire),
        .torp_valid  (torp_valid),
        .torp_mask   (torp_mask),
        .torp_ready  (torp_ready),
        .res_valid   (res_valid),
        .res_hit     (res_hit),
        .cursor_mask (cursor_mask),
        .fired_mask  (fired_mask),
        .hit_mask    (hit_mask),
        .shots_left  (shots_left),
        .reject      (reject),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [NC-1:0] oh(input int i);
        logic [NC-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; enable = 1'b0;
        btn_next = 1'b0; btn_prev = 1'b0; btn_fire = 1'b0;
        torp_ready = 1'b0; res_valid = 1'b0; res_hit = 1'b0;
        step();
        reset = 1'b0;
        m_cursor = 0; m_target = 0; m_shots = SHOTS;
        m_fired = '0; m_hit = '0;
        exp_torp_q.delete();
    endtask

    task automatic press_next();
        btn_next = 1'b1; step(); btn_next = 1'b0;
        m_cursor = (m_cursor + 1) % NC;
    endtask

    task automatic press_prev();
        btn_prev = 1'b1; step(); btn_prev = 1'b0;
        m_cursor = (m_cursor + NC - 1) % NC;
    endtask

    // Fire at the model cursor, optionally hold ready low, then complete the handshake.
    task automatic launch(input int ready_delay);
        logic [NC-1:0] exp_v;
        bit got;
        m_target = m_cursor;
        exp_torp_q.push_back(oh(m_cursor));
        btn_fire = 1'b1;
        torp_ready = (ready_delay == 0); // ready before valid must be ignored
        step();
        btn_fire = 1'b0;
        n_cmp++;
        if (torp_valid !== 1'b1) begin
            n_err++; $display("FAIL launch_valid: got %b want 1", torp_valid);
        end
        for (int i = 0; i < ready_delay; i++) begin
            n_cmp++;
            if (torp_valid !== 1'b1 || torp_mask !== oh(m_target)) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got valid=%b mask=%h want valid=1 mask=%h",
                         i, torp_valid, torp_mask, oh(m_target));
            end
            step();
        end
        torp_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (torp_valid === 1'b1) begin
                exp_v = exp_torp_q.pop_front();
                n_cmp++;
                if (torp_mask !== exp_v) begin
                    n_err++; $display("FAIL torp_mask: got %h want %h", torp_mask, exp_v);
                end
                step();
                torp_ready = 1'b0;
                n_cmp++;
                if (torp_valid !== 1'b0 || torp_mask !== '0) begin
                    n_err++;
                    $display("FAIL handshake_drop: got valid=%b mask=%h want 0/0", torp_valid, torp_mask);
                end
                got = 1;
            end else begin
                step();
            end
        end
        torp_ready = 1'b0;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL handshake_timeout: got no torp_valid want torp_valid within 8 cycles");
            exp_torp_q.delete();
        end
    endtask

    task automatic result(input logic hit);
        res_valid = 1'b1; res_hit = hit;
        step();
        res_valid = 1'b0; res_hit = 1'b0;
        m_fired[m_target] = 1'b1;
        m_hit[m_target]   = hit;
        m_shots--;
        n_cmp++;
        if (fired_mask !== m_fired || hit_mask !== m_hit || shots_left !== 4'(m_shots)) begin
            n_err++;
            $display("FAIL result_update: got fired=%h hit=%h shots=%0d want fired=%h hit=%h shots=%0d",
                     fired_mask, hit_mask, shots_left, m_fired, m_hit, m_shots);
        end
        n_cmp++;
        if (m_shots == 0) begin
            if (done !== 1'b1 || cursor_mask !== '0) begin
                n_err++;
                $display("FAIL result_done: got done=%b cursor=%h want done=1 cursor=0", done, cursor_mask);
            end
        end else if (done !== 1'b0 || cursor_mask !== oh(m_cursor)) begin
            n_err++;
            $display("FAIL result_aim: got done=%b cursor=%h want done=0 cursor=%h",
                     done, cursor_mask, oh(m_cursor));
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (torp_valid !== 1'b0 || torp_mask !== '0 || reject !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got valid=%b mask=%h reject=%b done=%b want all 0",
                     torp_valid, torp_mask, reject, done);
        end
        n_cmp++;
        if (fired_mask !== '0 || hit_mask !== '0 || shots_left !== 4'(SHOTS)) begin
            n_err++;
            $display("FAIL reset_hist: got fired=%h hit=%h shots=%0d want 0/0/%0d",
                     fired_mask, hit_mask, shots_left, SHOTS);
        end
        step(); step();
        n_cmp++;
        if (cursor_mask !== '0) begin
            n_err++; $display("FAIL idle_cursor: got %h want 0", cursor_mask);
        end
        enable = 1'b1;
        step();
        n_cmp++;
        if (cursor_mask !== oh(0)) begin
            n_err++; $display("FAIL aim_entry: got %h want %h", cursor_mask, oh(0));
        end
    endtask

    task automatic test_fire_basic();
        apply_reset();
        enable = 1'b1; step();
        press_next(); press_next(); press_next();
        n_cmp++;
        if (cursor_mask !== 28'h0000008) begin
            n_err++; $display("FAIL cursor3: got %h want 0000008", cursor_mask);
        end
        launch(0);
        result(1'b0);
    endtask

    task automatic test_wrap();
        apply_reset();
        enable = 1'b1; step();
        press_prev();
        n_cmp++;
        if (cursor_mask !== 28'h8000000) begin
            n_err++; $display("FAIL wrap_prev: got %h want 8000000", cursor_mask);
        end
        enable = 1'b0; step();
        n_cmp++;
        if (cursor_mask !== '0) begin
            n_err++; $display("FAIL disable_cursor: got %h want 0", cursor_mask);
        end
        enable = 1'b1; step();
        n_cmp++;
        if (cursor_mask !== 28'h8000000) begin
            n_err++; $display("FAIL cursor_kept: got %h want 8000000", cursor_mask);
        end
        press_next();
        n_cmp++;
        if (cursor_mask !== 28'h0000001) begin
            n_err++; $display("FAIL wrap_next: got %h want 0000001", cursor_mask);
        end
    endtask

    task automatic test_stall_and_reject();
        apply_reset();
        enable = 1'b1; step();
        for (int i = 0; i < 5; i++) press_next();
        launch(4);
        result(1'b1);
        n_cmp++;
        if (fired_mask !== 28'h20 || hit_mask !== 28'h20 || shots_left !== 4'(SHOTS - 1)) begin
            n_err++;
            $display("FAIL hit5: got fired=%h hit=%h shots=%0d want 20/20/%0d",
                     fired_mask, hit_mask, shots_left, SHOTS - 1);
        end
        btn_fire = 1'b1; step(); btn_fire = 1'b0;
        n_cmp++;
        if (reject !== 1'b1 || torp_valid !== 1'b0) begin
            n_err++; $display("FAIL reject_on: got reject=%b valid=%b want 1/0", reject, torp_valid);
        end
        step();
        n_cmp++;
        if (reject !== 1'b0 || torp_valid !== 1'b0 || shots_left !== 4'(SHOTS - 1)) begin
            n_err++;
            $display("FAIL reject_off: got reject=%b valid=%b shots=%0d want 0/0/%0d",
                     reject, torp_valid, shots_left, SHOTS - 1);
        end
        press_prev();
        btn_next = 1'b1; btn_prev = 1'b1; step(); btn_next = 1'b0; btn_prev = 1'b0;
        n_cmp++;
        if (cursor_mask !== oh(4)) begin
            n_err++; $display("FAIL next_prev_same: got %h want %h", cursor_mask, oh(4));
        end
        press_next();
        n_cmp++;
        if (cursor_mask !== oh(5)) begin
            n_err++; $display("FAIL after_same: got %h want %h", cursor_mask, oh(5));
        end
    endtask

    task automatic test_blink();
        apply_reset();
        enable = 1'b1; step();
        press_next(); // restart the blink phase
        for (int k = 0; k < 3 * BDIV; k++) begin
            logic [NC-1:0] exp_v;
            exp_v = (((k / BDIV) % 2) == 0) ? oh(m_cursor) : '0;
            n_cmp++;
            if (cursor_mask !== exp_v) begin
                n_err++; $display("FAIL blink[%0d]: got %h want %h", k, cursor_mask, exp_v);
            end
            step();
        end
    endtask

    task automatic test_stray_res();
        apply_reset();
        enable = 1'b1; step();
        press_next(); press_next();
        res_valid = 1'b1; res_hit = 1'b1; step(); res_valid = 1'b0; res_hit = 1'b0;
        n_cmp++;
        if (fired_mask !== '0 || hit_mask !== '0 || shots_left !== 4'(SHOTS) || cursor_mask !== oh(2)) begin
            n_err++;
            $display("FAIL stray_res: got fired=%h hit=%h shots=%0d cursor=%h want 0/0/%0d/%h",
                     fired_mask, hit_mask, shots_left, cursor_mask, SHOTS, oh(2));
        end
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        enable = 1'b1; step();
        press_next(); press_next(); press_next(); press_next();
        launch(1);
        apply_reset();
        n_cmp++;
        if (torp_valid !== 1'b0 || cursor_mask !== '0 || fired_mask !== '0 || hit_mask !== '0 ||
            shots_left !== 4'(SHOTS) || done !== 1'b0 || reject !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wait: got valid=%b cursor=%h fired=%h shots=%0d done=%b want reset values",
                     torp_valid, cursor_mask, fired_mask, shots_left, done);
        end
        enable = 1'b1; step();
        n_cmp++;
        if (cursor_mask !== oh(0)) begin
            n_err++; $display("FAIL reset_cursor0: got %h want %h", cursor_mask, oh(0));
        end
    endtask

    task automatic test_done();
        apply_reset();
        enable = 1'b1; step();
        for (int s = 0; s < SHOTS; s++) begin
            if (s > 0) press_next();
            launch(s);
            result(1'b0);
        end
        n_cmp++;
        if (done !== 1'b1 || hit_mask !== '0 || fired_mask !== 28'h7 || shots_left !== 4'd0) begin
            n_err++;
            $display("FAIL done_state: got done=%b hit=%h fired=%h shots=%0d want 1/0/7/0",
                     done, hit_mask, fired_mask, shots_left);
        end
        btn_next = 1'b1; step(); btn_next = 1'b0;
        btn_fire = 1'b1; torp_ready = 1'b1; step(); btn_fire = 1'b0;
        res_valid = 1'b1; res_hit = 1'b1; step(); res_valid = 1'b0; res_hit = 1'b0; torp_ready = 1'b0;
        step();
        n_cmp++;
        if (done !== 1'b1 || torp_valid !== 1'b0 || reject !== 1'b0 || cursor_mask !== '0 ||
            hit_mask !== '0 || fired_mask !== 28'h7 || shots_left !== 4'd0) begin
            n_err++;
            $display("FAIL done_frozen: got done=%b valid=%b cursor=%h hit=%h fired=%h shots=%0d want frozen",
                     done, torp_valid, cursor_mask, hit_mask, fired_mask, shots_left);
        end
    endtask

    initial begin
        test_reset();
        test_fire_basic();
        test_wrap();
        test_stall_and_reject();
        test_blink();
        test_stray_res();
        test_reset_in_wait();
        test_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/battleship_torpedo_launcher.md
# battleship_torpedo_launcher

Attacker-side initiator for the torpedo exchange on the 28-cell board (4 digits × 7 segments, cell i = bit i). Converts debounced button pulses into a moving cursor, issues a one-hot torpedo mask over a valid/ready handshake to the defender's hit-evaluation logic, then waits for the hit/miss result. It keeps the attacker's fired/hit history and shot budget, and drives a blinking cursor overlay for the display path.

## Interface
- CELLS, 28: board cells; mask width.
- MAX_SHOTS, 12: torpedoes per game; 1..15.
- BLINK_DIV, 25_000_000: clk cycles per cursor blink half-period; ≥2.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- enable  in  1  high while it is this attacker's turn.
- btn_next / btn_prev  in  1 each  single-cycle debounced pulses; move cursor +1 / −1.
- btn_fire  in  1  single-cycle pulse; fire at cursor.
- torp_valid  out  1  torpedo offered.
- torp_mask  out  CELLS  one-hot target; all zero when torp_valid=0.
- torp_ready  in  1  defender accepts torpedo.
- res_valid  in  1  result strobe from defender.
- res_hit  in  1  1 = hit; sampled with res_valid.
- cursor_mask  out  CELLS  blinking one-hot cursor overlay.
- fired_mask  out  CELLS  cells already fired on.
- hit_mask  out  CELLS  cells confirmed hit (subset of fired_mask).
- shots_left  out  4  remaining torpedoes.
- reject  out  1  one-cycle pulse: fire on an already-fired cell.
- done  out  1  shot budget exhausted.

## Operation
- States: IDLE, AIM, FIRE, WAIT_RES, DONE.
- IDLE: enable=1 → AIM. No cursor display.
- AIM: enable=0 → IDLE (cursor position kept). btn_next: cursor = (cursor+1) mod CELLS (27→0); btn_prev: 0→27. next and prev same cycle: no move. btn_fire with fired_mask[cursor]=0 → FIRE, latch target = cursor; with fired_mask[cursor]=1 → reject pulse, stay in AIM. Fire wins over moves in the same cycle; the cursor stays unchanged.
- FIRE: torp_valid=1, torp_mask = 1<<target, held stable until torp_valid && torp_ready → WAIT_RES. enable is ignored; buttons are ignored.
- WAIT_RES: on res_valid: fired_mask[target]=1, hit_mask[target]=res_hit, shots_left−1; next state DONE if new shots_left=0, otherwise AIM. res_valid in any other state is ignored. enable and buttons are ignored.
- DONE: terminal; outputs frozen; only reset leaves it.
- cursor_mask = (1<<cursor) when state=AIM and blink phase is on; otherwise 0.
- Blink counter free-runs 0..BLINK_DIV−1; phase toggles on wrap; phase resets to on at every AIM entry and on every cursor move.
- Cursor index is 5 bits, range 0..27; values ≥ CELLS are unreachable.

## Timing
- Reset values: state IDLE, cursor 0, target 0, fired_mask 0, hit_mask 0, shots_left MAX_SHOTS, blink phase on, counter 0. All outputs registered: torp_valid 0, torp_mask 0, cursor_mask 0, reject 0, done 0.
- btn_fire accepted at cycle N → torp_valid high at N+1.
- Handshake at cycle M (valid && ready) → torp_valid low at M+1, state WAIT_RES. A ready arriving before valid is ignored.
- res_valid at cycle R → masks and shots_left updated at R+1; cursor_mask visible again at R+1, or done=1 at R+1.
- Cursor move at N → cursor_mask reflects new position at N+1.
- reject asserts at N+1 for exactly one cycle.
- Reset mid-FIRE/WAIT_RES aborts the shot; the next cycle shows reset values. The defender must be reset concurrently.

## Structure
- battleship_pkg: CELLS constant, cell_idx_t (logic [4:0]), launcher_state_t enum. Shared with the defender-side hit logic.
- Sub-module battleship_blink_timer (parameter BLINK_DIV; inputs clk, reset, restart; output phase). This is the natural split.
- Remaining FSM, cursor and history logic stays flat in this block.

## Test plan
- Reset, enable=1, 3×btn_next, fire, torp_ready=1 → torp_mask=0x0000008 one cycle after fire; handshake completes next cycle.
- From cursor 0: btn_prev → cursor 27, cursor_mask=0x8000000. btn_next → cursor 0, cursor_mask=0x0000001.
- Fire at cell 5, hold torp_ready=0 for 4 cycles → torp_valid/torp_mask stable at 0x20; res_valid with res_hit=1 → fired_mask=hit_mask=0x20, shots_left=MAX_SHOTS−1.
- Fire again at cell 5 → reject pulses for 1 cycle, no torp_valid, shots_left unchanged. Same-cycle next+prev → cursor unchanged.
- MAX_SHOTS=2: two complete misses → done=1, hit_mask=0, further buttons and res_valid have no effect.
- Assert reset during WAIT_RES → next cycle all reset values. A stray res_valid in AIM is ignored; masks unchanged.
